// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi receive core: default generators, the
// erase-mask type, and the parity / Hamming-distance helpers.
package viterbi_pkg;

    localparam int          K_MAX      = 7;
    localparam logic [2:0]  G0_DEFAULT = 3'b111;
    localparam logic [2:0]  G1_DEFAULT = 3'b101;

    typedef logic [1:0] erase_mask_t;

    function automatic logic parity7(input logic [K_MAX-1:0] v);
        return ^v;
    endfunction

    // Distance between received and expected code bits; erased positions never count.
    function automatic logic [1:0] hamming2(input logic [1:0] rx, input logic [1:0] expd,
                                            input erase_mask_t er);
        logic [1:0] d;
        d = (rx ^ expd) & ~er;
        return {1'b0, d[1]} + {1'b0, d[0]};
    endfunction

endpackage

// File: rtl/viterbi_acs.sv
// One trellis state: add-compare-select against its two predecessors, plus
// the path-metric register and the register-exchange survivor for that state.
module viterbi_acs
    import viterbi_pkg::*;
#(
    parameter int              PM_W     = 6,
    parameter int              TB_DEPTH = 15,
    parameter logic            U_BIT    = 1'b0,
    parameter logic [PM_W-1:0] PM_INIT  = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                accept,
    input  logic                norm,
    input  logic [PM_W-1:0]     pm_a,
    input  logic [PM_W-1:0]     pm_b,
    input  logic [1:0]          bm_a,
    input  logic [1:0]          bm_b,
    input  logic [TB_DEPTH-2:0] sv_a,
    input  logic [TB_DEPTH-2:0] sv_b,
    output logic [PM_W-1:0]     pm_new,
    output logic [TB_DEPTH-1:0] sv_new,
    output logic [PM_W-1:0]     pm_q,
    output logic [TB_DEPTH-2:0] sv_q
);

    logic [PM_W:0]         sum_a_s;
    logic [PM_W:0]         sum_b_s;
    logic [PM_W-1:0]       cand_a_s;
    logic [PM_W-1:0]       cand_b_s;
    logic                  pick_b_s;
    logic [PM_W-1:0]       pm_d;
    logic [TB_DEPTH-2:0]   sv_d;

    // Saturating candidate metrics; ties keep the lower-index predecessor (a).
    always_comb begin
        sum_a_s  = {1'b0, pm_a} + (PM_W+1)'(bm_a);
        sum_b_s  = {1'b0, pm_b} + (PM_W+1)'(bm_b);
        cand_a_s = sum_a_s[PM_W] ? '1 : sum_a_s[PM_W-1:0];
        cand_b_s = sum_b_s[PM_W] ? '1 : sum_b_s[PM_W-1:0];
        pick_b_s = (cand_b_s < cand_a_s);
        pm_new   = pick_b_s ? cand_b_s : cand_a_s;
        sv_new   = {(pick_b_s ? sv_b : sv_a), U_BIT};
    end

    // Next register values. The stored survivor omits the oldest bit: it is
    // shifted out on every update and is only needed combinationally via sv_new.
    always_comb begin
        pm_d = pm_q;
        sv_d = sv_q;
        if (flush) begin
            pm_d = PM_INIT;
            sv_d = '0;
        end else if (accept) begin
            pm_d = norm ? {1'b0, pm_new[PM_W-2:0]} : pm_new;
            sv_d = sv_new[TB_DEPTH-2:0];
        end else begin
            pm_d = pm_q;
            sv_d = sv_q;
        end
    end

    // Metric and survivor state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pm_q <= PM_INIT;
            sv_q <= '0;
        end else begin
            pm_q <= pm_d;
            sv_q <= sv_d;
        end
    end

endmodule

// File: rtl/viterbi_rx_core.sv
// Hard-decision Viterbi decoder: NS parallel ACS units with register-exchange survivors.
// Defining VITERBI_ERASE_EN adds the in_erase port for depunctured input streams.
module viterbi_rx_core
    import viterbi_pkg::*;
#(
    parameter int           K        = 3,
    parameter logic [K-1:0] G0       = G0_DEFAULT,
    parameter logic [K-1:0] G1       = G1_DEFAULT,
    parameter int           TB_DEPTH = 15,
    parameter int           PM_W     = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_sym,
`ifdef VITERBI_ERASE_EN
    input  logic [1:0]      in_erase,
`endif
    input  logic            flush,
    output logic            out_valid,
    output logic            out_bit,
    output logic [PM_W-1:0] out_metric
);

    localparam int              NS      = 1 << (K-1);
    localparam int              IDX_W   = K-1;
    localparam int              CNT_W   = $clog2(TB_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TB_DEPTH-1);
    localparam logic [PM_W-1:0] PM_OFF  = PM_W'((1 << (PM_W-1)) - 1);

    erase_mask_t         erase_s;
    logic                accept_s;
    logic                norm_s;
    logic                best_bit_s;
    logic [PM_W-1:0]     min_pm_s;
    logic [IDX_W-1:0]    min_idx_s;
    logic [PM_W-1:0]     pm_q_s   [NS];
    logic [PM_W-1:0]     pm_new_s [NS];
    logic [TB_DEPTH-2:0] sv_q_s   [NS];
    logic [TB_DEPTH-1:0] sv_new_s [NS];
    logic [1:0]          bm_a_s   [NS];
    logic [1:0]          bm_b_s   [NS];

    logic                ready_q,  ready_d;
    logic                out_valid_q, out_valid_d;
    logic                out_bit_q,   out_bit_d;
    logic [PM_W-1:0]     out_metric_q, out_metric_d;
    logic [CNT_W-1:0]    count_q,  count_d;

`ifdef VITERBI_ERASE_EN
    assign erase_s = in_erase;
`else
    assign erase_s = '0;
`endif

    assign in_ready   = ready_q & ~flush;
    assign accept_s   = in_valid & in_ready;
    assign out_valid  = out_valid_q;
    assign out_bit    = out_bit_q;
    assign out_metric = out_metric_q;

    // State i is entered with u = i[K-2] from predecessors {i[K-3:0],0} and {i[K-3:0],1}.
    for (genvar i = 0; i < NS; i++) begin : g_state
        localparam int           PA    = (2 * i) % NS;
        localparam int           UB    = i / (NS / 2);
        localparam logic [K-1:0] REG_A = K'(UB * NS + PA);
        localparam logic [K-1:0] REG_B = K'(UB * NS + PA + 1);
        localparam logic [1:0]   EXP_A = {parity7(K_MAX'(REG_A & G0)), parity7(K_MAX'(REG_A & G1))};
        localparam logic [1:0]   EXP_B = {parity7(K_MAX'(REG_B & G0)), parity7(K_MAX'(REG_B & G1))};

        assign bm_a_s[i] = hamming2(in_sym, EXP_A, erase_s);
        assign bm_b_s[i] = hamming2(in_sym, EXP_B, erase_s);

        viterbi_acs #(
            .PM_W     (PM_W),
            .TB_DEPTH (TB_DEPTH),
            .U_BIT    (UB[0]),
            .PM_INIT  ((i == 0) ? '0 : PM_OFF)
        ) u_acs (
            .clk    (clk),
            .rst    (rst),
            .flush  (flush),
            .accept (accept_s),
            .norm   (norm_s),
            .pm_a   (pm_q_s[PA]),
            .pm_b   (pm_q_s[PA+1]),
            .bm_a   (bm_a_s[i]),
            .bm_b   (bm_b_s[i]),
            .sv_a   (sv_q_s[PA]),
            .sv_b   (sv_q_s[PA+1]),
            .pm_new (pm_new_s[i]),
            .sv_new (sv_new_s[i]),
            .pm_q   (pm_q_s[i]),
            .sv_q   (sv_q_s[i])
        );
    end

    // Minimum new metric, lowest index on ties; all metrics share the MSB when normalizing.
    always_comb begin
        min_pm_s  = pm_new_s[0];
        min_idx_s = '0;
        for (int s = 1; s < NS; s++) begin
            min_idx_s = (pm_new_s[s] < min_pm_s) ? IDX_W'(s) : min_idx_s;
            min_pm_s  = (pm_new_s[s] < min_pm_s) ? pm_new_s[s] : min_pm_s;
        end
        norm_s     = min_pm_s[PM_W-1];
        best_bit_s = sv_new_s[min_idx_s][TB_DEPTH-1];
    end

    // Output and symbol-count next state.
    always_comb begin
        ready_d      = 1'b1;
        out_valid_d  = 1'b0;
        out_bit_d    = out_bit_q;
        out_metric_d = out_metric_q;
        count_d      = count_q;
        if (flush) begin
            out_metric_d = '0;
            count_d      = '0;
        end else if (accept_s) begin
            out_valid_d  = (count_q == CNT_MAX);
            out_bit_d    = (count_q == CNT_MAX) ? best_bit_s : out_bit_q;
            out_metric_d = norm_s ? {1'b0, min_pm_s[PM_W-2:0]} : min_pm_s;
            count_d      = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
        end else begin
            count_d      = count_q;
        end
    end

    // Output registers and symbol counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_bit_q    <= 1'b0;
            out_metric_q <= '0;
            count_q      <= '0;
        end else begin
            ready_q      <= ready_d;
            out_valid_q  <= out_valid_d;
            out_bit_q    <= out_bit_d;
            out_metric_q <= out_metric_d;
            count_q      <= count_d;
        end
    end

endmodule

// File: tb/tb_viterbi_rx_core.sv
// Directed bench for viterbi_rx_core (K=3, 7/5 code, TB_DEPTH=15, PM_W=6),
// plus a random stream checked against a behavioral decoder model.
module tb_viterbi_rx_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_sym;
    logic       flush;
    logic       out_valid;
    logic       out_bit;
    logic [5:0] out_metric;
`ifdef VITERBI_ERASE_EN
    logic [1:0] in_erase;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [1:0] ref_sym  [20];
    int         exp_bits [6] = '{1, 0, 1, 1, 0, 0};
    int         got_bits [$];
    int         acc_cnt;
    int         first_out;
    int         stray;

    always #5 clk = ~clk;

    viterbi_rx_core dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sym     (in_sym),
`ifdef VITERBI_ERASE_EN
        .in_erase   (in_erase),
`endif
        .flush      (flush),
        .out_valid  (out_valid),
        .out_bit    (out_bit),
        .out_metric (out_metric)
    );

    task automatic check_eq(input string tag, input int got, input int expd);
        n_total++;
        if (got == expd) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, expd);
    endtask

    // One clock: drive at the falling edge, observe 1 time unit after the rising edge.
    task automatic cycle(input logic v, input logic [1:0] sym, input logic [1:0] er, input logic fl);
        logic acc;
        @(negedge clk);
        in_valid = v;
        in_sym   = sym;
        flush    = fl;
`ifdef VITERBI_ERASE_EN
        in_erase = er;
`else
        in_sym   = sym ^ (er & 2'b00);
`endif
        acc = v && !fl;
        @(posedge clk);
        #1;
        if (acc) acc_cnt++;
        if (out_valid) begin
            got_bits.push_back(int'(out_bit));
            if (first_out < 0) first_out = acc_cnt;
            if (!acc) stray++;
        end
    endtask

    task automatic do_flush(input logic v, input string tag);
        @(negedge clk);
        in_valid = v;
        in_sym   = 2'b11;
        flush    = 1'b1;
        #1;
        check_eq({tag, "_ready_low"}, int'(in_ready), 0);
        @(posedge clk);
        #1;
        check_eq({tag, "_valid_after"}, int'(out_valid), 0);
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    // mode 0: clean, 1: symbol 2 corrupted, 2: idle gap before each symbol, 3: odd c1 erased
    task automatic run_stream(input int mode);
        logic [1:0] sym;
        logic [1:0] er;
        got_bits.delete();
        acc_cnt   = 0;
        first_out = -1;
        stray     = 0;
        for (int j = 0; j < 20; j++) begin
            sym = ref_sym[j];
            er  = 2'b00;
            if (mode == 1 && j == 2) sym = 2'b10;
            if (mode == 3 && (j % 2) == 1) begin
                er  = 2'b01;
                sym = sym ^ 2'b01;
            end
            if (mode == 2) cycle(1'b0, 2'b00, 2'b00, 1'b0);
            cycle(1'b1, sym, er, 1'b0);
        end
        cycle(1'b0, 2'b00, 2'b00, 1'b0);
        cycle(1'b0, 2'b00, 2'b00, 1'b0);
    endtask

    task automatic check_stream(input string tag, input int exp_metric);
        check_eq({tag, "_count"}, got_bits.size(), 6);
        for (int i = 0; i < 6; i++)
            check_eq($sformatf("%s_bit%0d", tag, i), (i < got_bits.size()) ? got_bits[i] : -1, exp_bits[i]);
        check_eq({tag, "_first_out"}, first_out, 15);
        check_eq({tag, "_stray"}, stray, 0);
        check_eq({tag, "_metric"}, int'(out_metric), exp_metric);
    endtask

    function automatic logic [1:0] enc(input int st, input int u);
        logic [2:0] r;
        r = {u[0], st[1:0]};
        return {^(r & 3'b111), ^(r & 3'b101)};
    endfunction

    function automatic int hd(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] d;
        d = a ^ b;
        return int'(d[1]) + int'(d[0]);
    endfunction

    // Random stream against a behavioral Viterbi model with random idle gaps.
    task automatic run_random();
        int          pm [4];
        int          npm[4];
        logic [14:0] sv [4];
        logic [14:0] nsv[4];
        int          cnt;
        int          accepted;
        int          drops;
        int          prev_metric;
        int          best;
        int          bp;
        int          c;
        int          mn;
        int          mi;
        int          exp_valid;
        int          exp_bit;
        logic        v;
        logic [1:0]  sym;
        pm = '{0, 31, 31, 31};
        for (int s = 0; s < 4; s++) sv[s] = '0;
        cnt = 0; accepted = 0; drops = 0; prev_metric = 0;
        while (accepted < 1000) begin
            v   = ($urandom_range(0, 3) != 0);
            sym = 2'($urandom_range(0, 3));
            cycle(v, sym, 2'b00, 1'b0);
            exp_valid = 0;
            if (v) begin
                for (int ns = 0; ns < 4; ns++) begin
                    best = 0; bp = 0;
                    for (int b = 0; b < 2; b++) begin
                        c = pm[(ns * 2) % 4 + b] + hd(sym, enc((ns * 2) % 4 + b, ns / 2));
                        if (c > 63) c = 63;
                        if (b == 0 || c < best) begin
                            best = c;
                            bp   = (ns * 2) % 4 + b;
                        end
                    end
                    npm[ns] = best;
                    nsv[ns] = {sv[bp][13:0], 1'(ns / 2)};
                end
                mn = npm[0]; mi = 0;
                for (int s = 1; s < 4; s++)
                    if (npm[s] < mn) begin mn = npm[s]; mi = s; end
                exp_bit = int'(nsv[mi][14]);
                if (mn >= 32) begin
                    for (int s = 0; s < 4; s++) npm[s] -= 32;
                    mn -= 32;
                end
                pm = npm;
                sv = nsv;
                exp_valid = (cnt == 14) ? 1 : 0;
                if (cnt < 14) cnt++;
                accepted++;
                check_eq("rand_metric", int'(out_metric), mn);
                if (exp_valid == 1) check_eq("rand_bit", int'(out_bit), exp_bit);
                if (int'(out_metric) < prev_metric) drops++;
                prev_metric = int'(out_metric);
            end
            check_eq("rand_valid", int'(out_valid), exp_valid);
        end
        check_eq("rand_norm_seen", (drops > 0) ? 1 : 0, 1);
    endtask

    initial begin
        ref_sym[0] = 2'b11; ref_sym[1] = 2'b10; ref_sym[2] = 2'b00;
        ref_sym[3] = 2'b01; ref_sym[4] = 2'b01; ref_sym[5] = 2'b11;
        for (int j = 6; j < 20; j++) ref_sym[j] = 2'b00;

        rst      = 1'b0;
        in_valid = 1'b0;
        in_sym   = 2'b00;
        flush    = 1'b0;
`ifdef VITERBI_ERASE_EN
        in_erase = 2'b00;
`endif
        #12;
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_out_bit", int'(out_bit), 0);
        check_eq("rst_out_metric", int'(out_metric), 0);
        check_eq("rst_in_ready", int'(in_ready), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rst_ready_before_edge", int'(in_ready), 0);
        @(posedge clk);
        #1;
        check_eq("rst_ready_after_edge", int'(in_ready), 1);

        run_stream(0);
        check_stream("clean", 0);

        do_flush(1'b0, "flush_a");
        run_stream(1);
        check_stream("biterr", 1);

        do_flush(1'b0, "flush_b");
        run_stream(2);
        check_stream("gaps", 0);

        do_flush(1'b0, "flush_c");
        for (int j = 0; j < 10; j++) cycle(1'b1, 2'($urandom_range(0, 3)), 2'b00, 1'b0);
        do_flush(1'b1, "flush_busy");
        run_stream(0);
        check_stream("after_flush", 0);

`ifdef VITERBI_ERASE_EN
        do_flush(1'b0, "flush_e");
        run_stream(3);
        check_stream("erase", 0);
`endif

        do_flush(1'b0, "flush_r");
        run_random();

        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_rst_metric", int'(out_metric), 0);
        check_eq("async_rst_ready", int'(in_ready), 0);
        check_eq("async_rst_valid", int'(out_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/viterbi_rx_core.md
VITERBI_RX_CORE -- requirements
Module: viterbi_rx_core

Interface
REQ-001: Parameter K, default 3, constraint length (legal 3..7); trellis has NS = 2^(K-1) states.
REQ-002: Parameter G0, default 3'b111 (7 octal), generator 0, K bits, MSB taps the current input bit.
REQ-003: Parameter G1, default 3'b101 (5 octal), generator 1, same format as G0.
REQ-004: Parameter TB_DEPTH, default 15, survivor length in symbols (legal 4..64).
REQ-005: Parameter PM_W, default 6, path-metric width in bits (legal 4..12).
REQ-006: clk  input  1  single clock; all state updates on rising edge.
REQ-007: rst  input  1  reset, asynchronous assert, active-low.
REQ-008: in_valid  input  1  in_sym carries a code symbol.
REQ-009: in_ready  output  1  core accepts in_sym this cycle; symbol accepted when in_valid && in_ready.
REQ-010: in_sym  input  2  hard-decision code bits; [1]=c0 (G0), [0]=c1 (G1).
REQ-011: flush  input  1  single-cycle frame restart request.
REQ-012: out_valid  output  1  one-cycle pulse, out_bit holds a decoded bit.
REQ-013: out_bit  output  1  decoded information bit.
REQ-014: out_metric  output  PM_W  smallest path metric after the latest accepted symbol.

Function
REQ-015: Encoder model: state s of K-1 bits, s[K-2] most recent input; for input u, register {u,s}; c0 = XOR of ({u,s} & G0), c1 = XOR of ({u,s} & G1); next state = {u, s[K-2:1]}.
REQ-016: Branch metric = Hamming distance between in_sym and the expected {c0,c1}, range 0..2.
REQ-017: ACS per accepted symbol, per state: candidate = predecessor metric + branch metric, saturating at 2^PM_W-1; smaller candidate wins; tie -> predecessor with lower index wins; decision bit recorded.
REQ-018: Normalization: if minimum new metric >= 2^(PM_W-1), subtract 2^(PM_W-1) from every new metric in the same update (saturated metrics included).
REQ-019: Survivor storage is register-exchange: each state holds TB_DEPTH decoded bits, updated in the same cycle as its ACS by copying the winning predecessor's register shifted by one with u appended.
REQ-020: Output: on the cycle after acceptance of symbol j (0-based since reset/flush) with j >= TB_DEPTH-1, out_valid=1 and out_bit = oldest bit of the minimum-metric state (tie -> lowest index), i.e. information bit j-TB_DEPTH+1.
REQ-021: out_valid=0 in all other cycles; no output without an accepted symbol; gaps in in_valid insert no bubbles into results.
REQ-022: in_ready = 1 except in the cycle flush is high; flush has priority over a simultaneous in_valid (that symbol is not accepted).
REQ-023: flush: metrics -> state 0 = 0, others = 2^(PM_W-1)-1; survivors -> 0; symbol count -> 0; out_valid forced 0 the following cycle; undelivered bits discarded.
REQ-024: Symbol counter saturates at TB_DEPTH-1; never wraps.

Reset
REQ-025: rst low asynchronously applies the flush state of REQ-023 and drives out_valid=0, out_bit=0, out_metric=0, in_ready=0; in_ready rises the first clk edge after rst deasserts.

Configuration
REQ-026: Macro VITERBI_ERASE_EN defined: port in_erase input 2 added; erased bit ([1]->c0, [0]->c1) contributes 0 to branch metric (depuncturing). Undefined: port absent, both bits always counted.

Structure
REQ-027: Shared package viterbi_pkg holds parity and Hamming functions, default generator constants, and the erase-mask type.
REQ-028: Sub-module viterbi_acs (one add-compare-select + survivor register per state), instantiated NS times by generate.

Verification
REQ-029: K=3, TB_DEPTH=15, info 1,0,1,1,0,0 then 14 zeros encoded (11 10 00 01 01 11 00...) -> first out_valid 1 cycle after symbol 14, out_bits 1,0,1,1,0,0, out_metric 0.
REQ-030: Same stream with in_sym of symbol 2 changed 00->10 -> identical out_bits, out_metric 1 thereafter.
REQ-031: Same stream with in_valid low every other cycle -> identical out_bits, out_valid count equals accepted symbols minus 14.
REQ-032: 10 symbols accepted, flush with in_valid high, then REQ-029 stream -> flushed symbol not accepted, no stale bits, output as REQ-029.
REQ-033: 1000 random symbols, PM_W=6 -> metrics never exceed 63, no wrap; out_metric stays < 64 and normalization observed.
REQ-034: VITERBI_ERASE_EN, REQ-029 stream with c1 of every odd symbol erased (rate 2/3 puncture) -> identical out_bits.
